// File: rtl/nes_pkg.sv
// Shared constants and FSM state type for the NES pad reader.
// NES_PRESENCE_DETECT_EN adds a ninth clocked bit used for pad-presence detection.
package nes_pkg;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

`ifdef NES_PRESENCE_DETECT_EN
    localparam int unsigned LAST_BIT = 8;
`else
    localparam int unsigned LAST_BIT = 7;
`endif

    localparam int unsigned IDX_W = $clog2(LAST_BIT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StLow,
        StHigh,
        StDone
    } nes_state_e;

endpackage

// File: rtl/nes_sync.sv
// Two-flop synchronizer for the pad data line; resets to 1 (idle / released level).
module nes_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nes_controller_reader.sv
// Periodically polls a 4021-based NES pad and presents active-high button levels.
// Build option NES_PRESENCE_DETECT_EN clocks a ninth bit to detect a connected pad.
module nes_controller_reader
    import nes_pkg::*;
#(
    parameter int unsigned LATCH_CYCLES = 891,
    parameter int unsigned HALF_CYCLES  = 446,
    parameter int unsigned POLL_CYCLES  = 1237500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic       nes_connected
);

    localparam int unsigned PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int unsigned PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int unsigned POLL_W    = $clog2(POLL_CYCLES);

    localparam logic [PHASE_W-1:0] LATCH_END = PHASE_W'(LATCH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HALF_END  = PHASE_W'(HALF_CYCLES - 1);
    localparam logic [POLL_W-1:0]  POLL_END  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(LAST_BIT);

    // The poll tick must never land while a poll is still in progress.
    if (POLL_CYCLES <= LATCH_CYCLES + 18 * HALF_CYCLES + 2) begin : g_poll_too_short
        $error("POLL_CYCLES too small to fit one complete poll");
    end

    nes_state_e           state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [POLL_W-1:0]    poll_q, poll_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LAST_BIT:0]    shift_q, shift_d;
    logic [7:0]           buttons_q, buttons_d;
    logic                 valid_q, valid_d;
    logic                 latch_q, clk_q;
    logic                 data_sync;

    nes_sync u_sync (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (nes_data),
        .q_o   (data_sync)
    );

    assign poll_d = (poll_q == POLL_END) ? '0 : poll_q + POLL_W'(1);

`ifdef NES_PRESENCE_DETECT_EN
    logic conn_q, conn_d;
`endif

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q + PHASE_W'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        valid_d   = 1'b0;
`ifdef NES_PRESENCE_DETECT_EN
        conn_d    = conn_q;
`endif
        unique case (state_q)
            StIdle: begin
                phase_d = '0;
                if (poll_q == POLL_END) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                if (phase_q == LATCH_END) begin
                    phase_d = '0;
                    idx_d   = '0;
                    state_d = StLow;
                end
            end
            StLow: begin
                if (phase_q == HALF_END) begin
                    phase_d        = '0;
                    shift_d[idx_q] = ~data_sync;
                    if (idx_q == IDX_LAST) begin
                        // Buttons and strobe load on the same edge so they move together.
                        state_d = StDone;
                        valid_d = 1'b1;
`ifdef NES_PRESENCE_DETECT_EN
                        conn_d    = shift_d[LAST_BIT];
                        buttons_d = conn_d ? shift_d[BTN_RIGHT:BTN_A] : 8'h00;
`else
                        buttons_d = shift_d[BTN_RIGHT:BTN_A];
`endif
                    end else begin
                        state_d = StHigh;
                    end
                end
            end
            StHigh: begin
                if (phase_q == HALF_END) begin
                    phase_d = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = StLow;
                end
            end
            StDone: begin
                phase_d = '0;
                state_d = StIdle;
            end
            default: begin
                phase_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            poll_q    <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            buttons_q <= 8'h00;
            valid_q   <= 1'b0;
            latch_q   <= 1'b0;
            clk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            poll_q    <= poll_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            valid_q   <= valid_d;
            latch_q   <= (state_d == StLatch);
            clk_q     <= (state_d == StHigh);
        end
    end

`ifdef NES_PRESENCE_DETECT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conn_q <= 1'b0;
        end else begin
            conn_q <= conn_d;
        end
    end

    assign nes_connected = conn_q;
`else
    assign nes_connected = 1'b1;
`endif

    assign nes_latch     = latch_q;
    assign nes_clk       = clk_q;
    assign buttons       = buttons_q;
    assign buttons_valid = valid_q;

endmodule

// File: tb/tb_nes_controller_reader.sv
// Directed bench for nes_controller_reader with a behavioural 4021 pad model.
// Honours NES_PRESENCE_DETECT_EN so the same bench covers both builds.
module tb_nes_controller_reader;

    localparam int LATCH = 4;
    localparam int HALF  = 2;
    localparam int POLL  = 100;

`ifdef NES_PRESENCE_DETECT_EN
    localparam int   EXP_LAT    = 38;
    localparam int   EXP_PULSES = 8;
    localparam logic CONN_RST   = 1'b0;
    localparam logic CONN_NOPAD = 1'b0;
`else
    localparam int   EXP_LAT    = 34;
    localparam int   EXP_PULSES = 7;
    localparam logic CONN_RST   = 1'b1;
    localparam logic CONN_NOPAD = 1'b1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       nes_data;
    logic       nes_latch;
    logic       nes_clk;
    logic [7:0] buttons;
    logic       buttons_valid;
    logic       nes_connected;

    int checks = 0;
    int errors = 0;

    // 4021 pad model: parallel load while latched, shift on nes_clk rise, low = pressed.
    logic [7:0] pad_sr      = 8'hFF;
    logic [7:0] pad_pat     = 8'h00;
    logic       pad_ser     = 1'b0;
    logic       pad_present = 1'b1;

    always @(posedge nes_clk or posedge nes_latch) begin
        if (nes_latch) pad_sr <= ~pad_pat;
        else           pad_sr <= {pad_ser, pad_sr[7:1]};
    end

    assign nes_data = pad_present ? pad_sr[0] : 1'b1;

    always #5 clock = ~clock;

    nes_controller_reader #(
        .LATCH_CYCLES (LATCH),
        .HALF_CYCLES  (HALF),
        .POLL_CYCLES  (POLL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .nes_data      (nes_data),
        .nes_latch     (nes_latch),
        .nes_clk       (nes_clk),
        .buttons       (buttons),
        .buttons_valid (buttons_valid),
        .nes_connected (nes_connected)
    );

    task automatic wait_cycle();
        @(posedge clock);
        #1;
    endtask

    // Cycles until the next nes_latch rise (-1 if none within the budget).
    task automatic wait_latch(output int n, output int vcnt);
        logic prev;
        prev = nes_latch;
        n    = -1;
        vcnt = 0;
        for (int i = 1; i <= 300; i++) begin
            wait_cycle();
            if (buttons_valid) vcnt++;
            if (nes_latch && !prev) begin
                n = i;
                break;
            end
            prev = nes_latch;
        end
    endtask

    // Called on the cycle nes_latch first reads high (t=0); watches 60 cycles.
    task automatic observe_poll(output int latch_len, output int valid_at, output int valid_cnt,
                                output logic [7:0] valid_btn, output logic [7:0] btn_before,
                                output int pulses, output int hi_bad, output int per_bad);
        logic       prev_clk;
        logic [7:0] prev_btn;
        int         last_rise;
        int         hi_run;
        prev_clk   = 1'b0;
        prev_btn   = buttons;
        last_rise  = -1;
        hi_run     = 0;
        latch_len  = 0;
        valid_at   = -1;
        valid_cnt  = 0;
        valid_btn  = 8'h00;
        btn_before = 8'h00;
        pulses     = 0;
        hi_bad     = 0;
        per_bad    = 0;
        for (int t = 0; t < 60; t++) begin
            if (nes_latch) latch_len++;
            if (nes_clk) begin
                if (!prev_clk) begin
                    pulses++;
                    if (last_rise >= 0 && t - last_rise != 2 * HALF) per_bad++;
                    last_rise = t;
                    hi_run    = 0;
                end
                hi_run++;
            end else if (prev_clk && hi_run != HALF) begin
                hi_bad++;
            end
            if (buttons_valid) begin
                if (valid_cnt == 0) begin
                    valid_at   = t;
                    valid_btn  = buttons;
                    btn_before = prev_btn;
                end
                valid_cnt++;
            end
            prev_clk = nes_clk;
            prev_btn = buttons;
            wait_cycle();
        end
    endtask

    task automatic test_reset();
        int n, vcnt;
        reset = 1'b1;
        repeat (3) wait_cycle();
        checks++; if (nes_latch !== 1'b0) begin errors++; $display("FAIL rst_latch: got %b want 0", nes_latch); end
        checks++; if (nes_clk !== 1'b0) begin errors++; $display("FAIL rst_clk: got %b want 0", nes_clk); end
        checks++; if (buttons !== 8'h00) begin errors++; $display("FAIL rst_buttons: got %h want 00", buttons); end
        checks++; if (buttons_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", buttons_valid); end
        checks++; if (nes_connected !== CONN_RST) begin errors++; $display("FAIL rst_conn: got %b want %b", nes_connected, CONN_RST); end
        reset = 1'b0;
        wait_cycle();
        checks++; if (nes_latch !== 1'b0 || nes_clk !== 1'b0) begin errors++; $display("FAIL rel_outputs: got latch %b clk %b want 0 0", nes_latch, nes_clk); end
        wait_latch(n, vcnt);
        checks++; if (n !== 99) begin errors++; $display("FAIL first_latch_delay: got %0d want 99", n); end
    endtask

    task automatic test_pattern();
        int n, vcnt, ll, va, vc, pu, hb, pb;
        logic [7:0] vb, bb;
        wait_cycle();
        pad_present = 1'b1;
        pad_ser     = 1'b0;
        pad_pat     = 8'h5A;
        wait_latch(n, vcnt);
        checks++; if (n !== POLL - 1) begin errors++; $display("FAIL pat_latch_gap: got %0d want %0d", n, POLL - 1); end
        observe_poll(ll, va, vc, vb, bb, pu, hb, pb);
        checks++; if (va !== EXP_LAT) begin errors++; $display("FAIL pat_latency: got %0d want %0d", va, EXP_LAT); end
        checks++; if (vc !== 1) begin errors++; $display("FAIL pat_valid_count: got %0d want 1", vc); end
        checks++; if (vb !== 8'h5A) begin errors++; $display("FAIL pat_buttons: got %h want 5a", vb); end
        checks++; if (bb !== 8'h00) begin errors++; $display("FAIL pat_before: got %h want 00", bb); end
        checks++; if (buttons !== 8'h5A) begin errors++; $display("FAIL pat_hold: got %h want 5a", buttons); end
        wait_latch(n, vcnt);
        checks++; if (n !== POLL - 60) begin errors++; $display("FAIL latch_period: got %0d want %0d", n + 60, POLL); end
        checks++; if (buttons !== 8'h5A || vcnt !== 0) begin errors++; $display("FAIL pat_hold_idle: got %h strobes %0d want 5a 0", buttons, vcnt); end
    endtask

    task automatic test_timing();
        int ll, va, vc, pu, hb, pb;
        logic [7:0] vb, bb;
        observe_poll(ll, va, vc, vb, bb, pu, hb, pb);
        checks++; if (ll !== LATCH) begin errors++; $display("FAIL latch_len: got %0d want %0d", ll, LATCH); end
        checks++; if (pu !== EXP_PULSES) begin errors++; $display("FAIL clk_pulses: got %0d want %0d", pu, EXP_PULSES); end
        checks++; if (hb !== 0) begin errors++; $display("FAIL clk_high_len: got %0d bad want 0", hb); end
        checks++; if (pb !== 0) begin errors++; $display("FAIL clk_period: got %0d bad want 0", pb); end
        checks++; if (va !== EXP_LAT || vb !== 8'h5A) begin errors++; $display("FAIL repeat_poll: got %0d/%h want %0d/5a", va, vb, EXP_LAT); end
    endtask

    task automatic test_no_pad();
        int n, vcnt, ll, va, vc, pu, hb, pb;
        logic [7:0] vb, bb;
        pad_present = 1'b0;
        wait_latch(n, vcnt);
        observe_poll(ll, va, vc, vb, bb, pu, hb, pb);
        checks++; if (vc !== 1 || va !== EXP_LAT) begin errors++; $display("FAIL nopad_valid: got %0d at %0d want 1 at %0d", vc, va, EXP_LAT); end
        checks++; if (vb !== 8'h00) begin errors++; $display("FAIL nopad_buttons: got %h want 00", vb); end
        checks++; if (nes_connected !== CONN_NOPAD) begin errors++; $display("FAIL nopad_conn: got %b want %b", nes_connected, CONN_NOPAD); end
        checks++; if (pu !== EXP_PULSES) begin errors++; $display("FAIL nopad_pulses: got %0d want %0d", pu, EXP_PULSES); end
        pad_present = 1'b1;
    endtask

`ifdef NES_PRESENCE_DETECT_EN
    task automatic test_presence();
        int n, vcnt, ll, va, vc, pu, hb, pb;
        logic [7:0] vb, bb;
        pad_present = 1'b1;
        pad_ser     = 1'b0;
        pad_pat     = 8'h81;
        wait_latch(n, vcnt);
        observe_poll(ll, va, vc, vb, bb, pu, hb, pb);
        checks++; if (nes_connected !== 1'b1) begin errors++; $display("FAIL pres_conn: got %b want 1", nes_connected); end
        checks++; if (vb !== 8'h81) begin errors++; $display("FAIL pres_buttons: got %h want 81", vb); end
        checks++; if (va !== 38) begin errors++; $display("FAIL pres_latency: got %0d want 38", va); end
    endtask
`endif

    task automatic test_reset_mid_poll();
        int n, vcnt, ll, va, vc, pu, hb, pb;
        logic [7:0] vb, bb;
        pad_present = 1'b1;
        pad_pat     = 8'hFF;
        wait_latch(n, vcnt);
        observe_poll(ll, va, vc, vb, bb, pu, hb, pb);
        checks++; if (vb !== 8'hFF) begin errors++; $display("FAIL mid_pre_buttons: got %h want ff", vb); end
        pad_pat = 8'h3C;
        wait_latch(n, vcnt);
        // Fourth HIGH phase covers t=18..19 after the latch rise.
        repeat (18) wait_cycle();
        checks++; if (nes_clk !== 1'b1) begin errors++; $display("FAIL mid_in_high: got %b want 1", nes_clk); end
        reset = 1'b1;
        #1;
        checks++; if (nes_clk !== 1'b0 || nes_latch !== 1'b0) begin errors++; $display("FAIL mid_abort: got clk %b latch %b want 0 0", nes_clk, nes_latch); end
        checks++; if (buttons !== 8'h00) begin errors++; $display("FAIL mid_buttons: got %h want 00", buttons); end
        checks++; if (nes_connected !== CONN_RST) begin errors++; $display("FAIL mid_conn: got %b want %b", nes_connected, CONN_RST); end
        vcnt = 0;
        for (int i = 0; i < 3; i++) begin
            wait_cycle();
            if (buttons_valid) vcnt++;
        end
        reset = 1'b0;
        wait_cycle();
        if (buttons_valid) vcnt++;
        wait_latch(n, vc);
        vcnt += vc;
        checks++; if (vcnt !== 0) begin errors++; $display("FAIL mid_no_strobe: got %0d strobes want 0", vcnt); end
        checks++; if (n !== 99) begin errors++; $display("FAIL mid_restart_delay: got %0d want 99", n); end
        observe_poll(ll, va, vc, vb, bb, pu, hb, pb);
        checks++; if (vc !== 1 || va !== EXP_LAT) begin errors++; $display("FAIL mid_recover_valid: got %0d at %0d want 1 at %0d", vc, va, EXP_LAT); end
        checks++; if (vb !== 8'h3C) begin errors++; $display("FAIL mid_recover_buttons: got %h want 3c", vb); end
        checks++; if (nes_connected !== 1'b1) begin errors++; $display("FAIL mid_recover_conn: got %b want 1", nes_connected); end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_timing();
        test_no_pad();
`ifdef NES_PRESENCE_DETECT_EN
        test_presence();
`endif
        test_reset_mid_poll();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timed out");
    end

endmodule
